// File: rtl/p_table_pkg.sv
// Byte permutation used by the CS-cipher round function and its inverse.
// p_lookup(x) = rotl1(5*x + 8'h63); multiplication by an odd constant is a
// bijection mod 256, so the inverse undoes each step in reverse order
// (205 is the multiplicative inverse of 5 mod 256).
package p_table_pkg;

    function automatic logic [7:0] p_lookup(input logic [7:0] x);
        logic [7:0] y;
        y = (x * 8'd5) + 8'h63;
        return {y[6:0], y[7]};
    endfunction

    function automatic logic [7:0] p_inv_lookup(input logic [7:0] y);
        logic [7:0] r;
        r = {y[0], y[7:1]};
        r = r - 8'h63;
        return r * 8'd205;
    endfunction

endpackage

// File: rtl/fci_inv_unit.sv
// Byte-serial inverse of the fci round function: un-transpose on capture,
// then one inverse lookup per cycle, byte 0 first.
//
// state  | meaning
// -------+--------------------------------------------------------
// S_IDLE | waiting for a word, in_ready high
// S_BUSY | processing byte cnt, eight cycles
// S_DONE | result held in res, out_valid high until taken
module fci_inv_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_ci,
    input  logic [63:0] in_oword,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_iword,
    output logic        busy
);
    import p_table_pkg::p_inv_lookup;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [63:0] ci_q, ci_d;
    logic [63:0] t_q, t_d;
    logic [63:0] res_q, res_d;
    logic [5:0]  bit_idx;

    // The forward 8x8 bit transpose is its own inverse: pure wiring.
    function automatic logic [63:0] untranspose(input logic [63:0] w);
        logic [63:0] t;
        t = '0;
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                t[8*b+a] = w[8*a+b];
            end
        end
        return t;
    endfunction

    assign bit_idx = {cnt_q, 3'b000};

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ci_d    = ci_q;
        t_d     = t_q;
        res_d   = res_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    ci_d    = in_ci;
                    t_d     = untranspose(in_oword);
                    res_d   = '0;
                    cnt_d   = 3'd0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                res_d[bit_idx +: 8] = p_inv_lookup(t_q[bit_idx +: 8]) ^ ci_q[bit_idx +: 8];
                if (cnt_q == 3'd7) begin
                    cnt_d   = 3'd0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any partial result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            ci_q    <= '0;
            t_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ci_q    <= ci_d;
            t_q     <= t_d;
            res_q   <= res_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_BUSY) || (state_q == S_DONE);
    assign out_iword = res_q;

endmodule

// File: tb/tb_fci_inv_unit.sv
// Scoreboard bench for fci_inv_unit: words are built with an independent
// forward fci model, expected iwords queued on accept and checked on output.
module tb_fci_inv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_ci = '0;
    logic [63:0] in_oword = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_iword;
    logic        busy;

    int          n_tests = 0;
    int          n_fail = 0;
    int          n_out = 0;
    logic [63:0] sb_q[$];
    logic [63:0] mon_exp;

    fci_inv_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ci     (in_ci),
        .in_oword  (in_oword),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_iword (out_iword),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_p(input logic [7:0] x);
        logic [7:0] y;
        y = (x * 8'd5) + 8'h63;
        return {y[6:0], y[7]};
    endfunction

    function automatic logic [63:0] model_fci(input logic [63:0] ci, input logic [63:0] iw);
        logic [63:0] p;
        logic [63:0] o;
        for (int k = 0; k < 8; k++) p[8*k +: 8] = model_p(iw[8*k +: 8] ^ ci[8*k +: 8]);
        for (int a = 0; a < 8; a++)
            for (int b = 0; b < 8; b++)
                o[8*a+b] = p[8*b+a];
        return o;
    endfunction

    // Output side of the scoreboard; handshake completes at the next posedge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_extra_out", 64'(sb_q.size()), 64'd1);
            end else begin
                mon_exp = sb_q.pop_front();
                chk("out_iword", out_iword, mon_exp);
                n_out++;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accept edge.
    task automatic send(input logic [63:0] ci, input logic [63:0] iw);
        int n;
        in_ci    = ci;
        in_oword = model_fci(ci, iw);
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("in_accept", 64'(in_ready), 64'd1);
        sb_q.push_back(iw);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_ci    = {$urandom, $urandom};
        in_oword = {$urandom, $urandom};
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        chk(tag, 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        int n;
        int bad_v, bad_d, bad_r, ghost;
        int out_before;
        logic [63:0] iw_bp;
        bit soak_done;

        // Reset values
        #12;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_iword", out_iword, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Inverse table
        for (int x = 0; x < 256; x++) begin
            chk("p_inv_table", 64'(p_table_pkg::p_inv_lookup(model_p(8'(x)))), 64'(x));
        end

        // Zero key round trip and latency
        out_ready = 1'b1;
        send(64'h0, 64'h0);
        n = 1;
        @(negedge clk);
        chk("busy_after_accept", 64'(busy), 64'd1);
        while (!out_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 64'(n), 64'd9);
        drain("drain_zero");

        // Fixed vectors
        send(64'h0123456789ABCDEF, 64'hFEDCBA9876543210);
        drain("drain_vec1");
        send(64'hA5A5A5A5A5A5A5A5, 64'h5A5A5A5A5A5A5A5A);
        drain("drain_vec2");

        // Output backpressure with an ignored input word
        out_ready = 1'b0;
        iw_bp = 64'h1122334455667788;
        send(64'hDEADBEEFCAFEF00D, iw_bp);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("bp_valid_rise", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        in_ci    = 64'h0F0F0F0F0F0F0F0F;
        in_oword = model_fci(64'h0F0F0F0F0F0F0F0F, 64'hFFFFFFFF00000000);
        in_valid = 1'b1;
        bad_v = 0; bad_d = 0; bad_r = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!out_valid) bad_v++;
            if (out_iword !== iw_bp) bad_d++;
            if (in_ready) bad_r++;
        end
        chk("bp_valid_held", 64'(bad_v), 64'd0);
        chk("bp_data_stable", 64'(bad_d), 64'd0);
        chk("bp_in_ready_low", 64'(bad_r), 64'd0);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain("drain_bp");
        ghost = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid || busy) ghost++;
        end
        chk("bp_ignored_word", 64'(ghost), 64'd0);
        chk("bp_idle_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Reset in the middle of BUSY
        send(64'h13579BDF2468ACE0, 64'h0F1E2D3C4B5A6978);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_out_iword", out_iword, 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(64'hFFFF0000FFFF0000, 64'h0123012301230123);
        drain("drain_after_rst");

        // Random soak with gaps on both sides
        out_before = n_out;
        soak_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    repeat ($urandom_range(0, 3)) begin
                        @(posedge clk);
                        #1;
                    end
                    send({$urandom, $urandom}, {$urandom, $urandom});
                end
                soak_done = 1'b1;
            end
            begin
                while (!soak_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain("soak_drain");
        chk("soak_count", 64'(n_out - out_before), 64'd200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fci_inv_unit.md
# fci_inv_unit

Byte-serial inverse of the CS-cipher round function `fci_func`, used on the decryption datapath. Given a round output word `oword` and the round constant/key word `ci`, it returns `iword` such that `fci_func(ci, iword) == oword`. It reuses one inverse P-box lookup over eight cycles rather than eight parallel lookups. It sits between the round-key source and the decryption round register, with valid/ready handshakes on both sides.

## Interface

Parameters: none. Widths are fixed at 64-bit words and 8-bit bytes.

Ports:

- `clk` input 1 — single clock; all state changes on its rising edge.
- `rst_n` input 1 — reset, asynchronous assert, active low.
- `in_valid` input 1 — `in_ci` and `in_oword` are valid.
- `in_ready` output 1 — the unit can accept a word.
- `in_ci` input 64 — round constant/key word.
- `in_oword` input 64 — `fci_func` output word to invert.
- `out_valid` output 1 — `out_iword` holds a result.
- `out_ready` input 1 — downstream accepts the result.
- `out_iword` output 64 — recovered `fci_func` input word.
- `busy` output 1 — high in BUSY or DONE.

## Operation

- The inverse S-box lookup is `p_table_pkg::p_inv_lookup(byte)`, added to the package beside `p_lookup`. It is defined by `p_inv_lookup(p_lookup(x)) == x` for all 256 values of x.
- **Un-transpose.** The forward transform is `out[8a+b] = p[8b+a]`, an 8x8 bit-matrix transpose, which is its own inverse. Compute `t[8b+a] = in_oword[8a+b]` for a,b in 0..7. This is pure wiring, applied when the word is captured.
- **Per-byte step.** For each byte k: `iword[8k +: 8] = p_inv_lookup(t[8k +: 8]) ^ in_ci[8k +: 8]`.
- **Registers:**
  - `ci_r` (64), `t_r` (64) and `res_r` (64).
  - `cnt` (3 bits).
  - `state`, one of IDLE, BUSY, DONE.
- **State machine:**
  - **IDLE.** `in_ready=1`. On `in_valid && in_ready`: load `ci_r`; load `t_r` with the un-transposed `in_oword`; clear `res_r` to 0; set `cnt=0`; go to BUSY.
  - **BUSY.** Each cycle: write `res_r[8*cnt +: 8] = p_inv_lookup(t_r[8*cnt +: 8]) ^ ci_r[8*cnt +: 8]`. Byte 0 is processed first and byte 7 last.
    - If `cnt==7`: go to DONE and set `cnt=0`.
    - Otherwise: increment `cnt`.
  - **DONE.** `out_valid=1`. On `out_valid && out_ready`: go to IDLE.
- `out_iword` is driven from `res_r` at all times, but is meaningful only while `out_valid=1`.
- Input handshake:
  - `in_ready` is high only in IDLE. A word cannot be accepted in BUSY or DONE, including in the same cycle that DONE completes its output handshake.
  - The input fields are sampled only on the accept edge. Changes to `in_*` after acceptance have no effect.
- Output handshake:
  - `out_valid`, once high, stays high and `out_iword` stays stable until the handshake completes.
  - `out_ready` has no effect outside DONE.
- **Reset** (asynchronous, any state, including mid-BUSY):
  - state goes to IDLE;
  - `cnt`, `ci_r`, `t_r` and `res_r` clear to 0;
  - the partial result is discarded.
- Reset values of the outputs: `in_ready=1`, `out_valid=0`, `out_iword=0`, `busy=0`.

## Timing

- Accept edge at cycle N. BUSY occupies cycles N+1 through N+8 (bytes 0..7). `out_valid` rises at N+9.
- Latency from accept to `out_valid` is 9 cycles.
- With `out_ready` held high, the output handshake occurs at the N+9 edge and `in_ready` rises at N+10. Maximum throughput is one word per 10 cycles.
- There are no combinational paths from inputs to outputs. `in_ready`, `out_valid` and `busy` decode directly from `state`.
- The critical path is the 8-bit mux on `t_r` by `cnt`, then `p_inv_lookup`, then the XOR, then the `res_r` byte enable.

## Test plan

- **Round-trip, zero key.** `ci=0`, `oword = fci_func(0, 64'h0)` -> `out_iword=64'h0` with `out_valid` rising exactly 9 cycles after accept.
- **Round-trip, fixed vectors.** `ci=64'h0123456789ABCDEF` with `iword=64'hFEDCBA9876543210`, and `ci=64'hA5A5A5A5A5A5A5A5` with `iword=64'h5A5A5A5A5A5A5A5A`. Drive `oword` from the `fci_func` reference model -> `out_iword` equals the original `iword`.
- **Output backpressure.** Hold `out_ready=0` for 20 cycles after `out_valid` rises -> `out_valid` stays 1, `out_iword` is stable, `in_ready=0` throughout. Also assert `in_valid` with a new word during this time -> the new word is ignored (it is not accepted later unless re-presented).
- **Reset mid-operation.** Pulse `rst_n` low at cycle N+4 of a transaction -> `in_ready=1`, `out_valid=0`, `out_iword=0`, `busy=0` immediately (asynchronous). A fresh word accepted after reset gives the correct result.
- **Random soak.** 200 random `(ci, iword)` pairs. Compute `oword` with the `fci_func` model and apply random `in_valid`/`out_ready` gaps -> every `out_iword` equals its `iword`, in order, with no drops or duplicates.
- **Table check.** For all 256 x, `p_inv_lookup(p_lookup(x)) == x`.
